p_mem_wb_stage: RTL and testbench
=================================

Name: p_mem_wb_stage

Overview:
- Memory-access and write-back stage of the RV32IM pipeline, and the producer of the register-file write port (ext_reg_write_en / ext_rd_addr / ext_rd_data) that the decode stage consumes.
- Takes EX/MEM results and runs loads/stores over a req/ack data-memory handshake.
- Aligns and extends load data, selects the write-back source and registers the write-back.
- Stalls upstream while a memory access is outstanding.

Parameters:
- WIDTH, 32: datapath width.
- MAX_WAIT, 16: maximum WAIT cycles before bus timeout; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- en  in  1  stage enable; gates acceptance of new instructions only
- i_valid  in  1  EX/MEM holds a real instruction
- i_reg_write_en, i_mem_write_en, i_mem_read_en  in  1 each  control from EX/MEM
- i_wb_sel  in  2  write-back source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM
- i_funct3  in  3  load/store size and sign
- i_rd_addr  in  5  destination register
- i_alu_result  in  32  ALU result / effective address
- i_rs2_data  in  32  store data
- i_pc_plus_4, i_imm  in  32 each  write-back candidates
- o_dmem_req  out  1  memory request, held until ack
- o_dmem_we  out  1  store when high
- o_dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_ack  in  1  request complete; rdata valid for loads
- i_dmem_rdata  in  32  load word
- o_stall  out  1  freeze upstream stages
- o_bus_err  out  1  one-cycle timeout pulse
- ext_reg_write_en  out  1  register-file write enable
- ext_rd_addr  out  5  register-file write address
- ext_rd_data  out  32  register-file write data

Behaviour:
- Reset (async, rst=0): FSM to IDLE. o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_addr, o_dmem_wdata = 0. ext_* = 0, o_bus_err = 0, wait counter = 0. A request in flight is dropped immediately.
- FSM states: IDLE, WAIT.
- IDLE, accepting (en & i_valid):
  - Non-memory instruction: load WB registers at the edge; ext_* valid the next cycle (latency 1).
  - Memory instruction (read|write): o_stall=1 combinationally. At the edge, register req/we/addr/wdata/be, latch funct3/rd/wb_sel/addr[1:0], go to WAIT. WB registers load a bubble.
- IDLE, not accepting (en=0 or i_valid=0): WB registers load a bubble.
- WAIT:
  - o_dmem_* held stable and o_stall=1 while i_dmem_ack=0.
  - Cycle with i_dmem_ack=1: o_stall=0. At that edge req drops, the aligned load data (or the store's bubble) loads into the WB registers, and the FSM returns to IDLE. Upstream advances on the same edge.
  - Load latency: ext_* are valid the cycle after the ack cycle.
- Timeout (MAX_WAIT>0): counter increments each WAIT cycle without ack. At MAX_WAIT: req drops, o_bus_err=1 for one cycle, no register write, return to IDLE with o_stall=0.
- Bubble: ext_reg_write_en=0. ext_rd_addr/ext_rd_data hold their previous values.
- ext_reg_write_en is a one-cycle pulse per retired instruction. It is forced 0 when rd=0.
- Store lanes (off = addr[1:0]):
  - SB: be = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011<<{off[1],1'b0}, wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111, wdata = rs2.
- Loads: be=4'b1111. Data = rdata>>(off*8), then:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: passthrough.
- Write-back mux: i_wb_sel selects ALU, aligned MEM, PC+4 or IMM. Loads always use MEM.
- An ack arriving in IDLE is ignored.
- rst asserted during WAIT aborts the access. After reset, no write-back occurs for that access.

Optional Feature:
- Macro: P_MEM_WB_MISALIGN_CHECK_EN.
- With the macro: adds output o_misaligned (1 bit). Misaligned cases are LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0. For these: no request, no stall, no write-back, o_misaligned pulses for one cycle.
- Without the macro: no check and no port. Lanes follow the formulas above with off truncated.

Test Plan:
- ADD result 0x0000_0042, rd=5, wb_sel=00 -> next cycle ext_reg_write_en=1, ext_rd_addr=5, ext_rd_data=0x42, o_stall=0 throughout.
- LB addr 0x1003, ack after 3 cycles with rdata 0x80AA_BBCC -> o_stall high 4 cycles, then ext_rd_data=0xFFFF_FF80. Repeat as LBU -> 0x0000_0080.
- SH rs2=0x1234_ABCD, addr 0x2002 -> o_dmem_be=4'b1100, wdata=0xABCD_ABCD, addr=0x2000, ext_reg_write_en stays 0.
- JAL, rd=1, pc_plus_4=0x104, wb_sel=10 -> ext_rd_data=0x104. Same with rd=0 -> ext_reg_write_en=0.
- LW with ack never asserted, MAX_WAIT=16 -> req drops after 16 WAIT cycles, o_bus_err pulses once, no write, o_stall releases.
- rst low mid-WAIT -> o_dmem_req=0 immediately. A late ack after reset produces no write-back. With the macro: LW at 0x1001 -> o_misaligned=1, o_dmem_req never asserted.

Source files
------------

// File: rtl/p_mem_wb_stage.sv
// p_mem_wb_stage: memory-access and write-back stage of the RV32IM pipeline.
// Runs loads/stores over a req/ack data-memory handshake, aligns load data,
// selects the write-back source and drives the register-file write port.
// Optional misaligned-access trap: define P_MEM_WB_MISALIGN_CHECK_EN.
module p_mem_wb_stage #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             i_valid,
  input  logic             i_reg_write_en,
  input  logic             i_mem_write_en,
  input  logic             i_mem_read_en,
  input  logic [1:0]       i_wb_sel,
  input  logic [2:0]       i_funct3,
  input  logic [4:0]       i_rd_addr,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic [WIDTH-1:0] i_pc_plus_4,
  input  logic [WIDTH-1:0] i_imm,
  output logic             o_dmem_req,
  output logic             o_dmem_we,
  output logic [WIDTH-1:0] o_dmem_addr,
  output logic [WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]       o_dmem_be,
  input  logic             i_dmem_ack,
  input  logic [WIDTH-1:0] i_dmem_rdata,
  output logic             o_stall,
  output logic             o_bus_err,
  output logic             ext_reg_write_en,
  output logic [4:0]       ext_rd_addr,
  output logic [WIDTH-1:0] ext_rd_data
`ifdef P_MEM_WB_MISALIGN_CHECK_EN
  ,
  output logic             o_misaligned
`endif
);

  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic             accept, is_mem, misal_now, mem_go, alu_go, tmo_hit;

  // Access context latched when the request is issued
  logic [2:0]       f3_p0;
  logic [4:0]       rd_p0;
  logic [1:0]       off_p0;
  logic             rw_p0;
  logic             ld_p0;

  // Shift the addressed lane down and extend according to funct3
  function automatic logic [WIDTH-1:0] load_align(input logic [WIDTH-1:0] rdata,
                                                  input logic [1:0] off,
                                                  input logic [2:0] f3);
    logic [WIDTH-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  load_align = {{(WIDTH-8){sh[7]}}, sh[7:0]};
      3'b001:  load_align = {{(WIDTH-16){sh[15]}}, sh[15:0]};
      3'b100:  load_align = {{(WIDTH-8){1'b0}}, sh[7:0]};
      3'b101:  load_align = {{(WIDTH-16){1'b0}}, sh[15:0]};
      default: load_align = sh;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off,
                                          input logic is_write);
    if (!is_write) begin
      store_be = 4'b1111;
    end else begin
      case (f3[1:0])
        2'b00:   store_be = 4'b0001 << off;
        2'b01:   store_be = 4'b0011 << {off[1], 1'b0};
        default: store_be = 4'b1111;
      endcase
    end
  endfunction

  function automatic logic [WIDTH-1:0] store_wdata(input logic [2:0] f3,
                                                   input logic [WIDTH-1:0] rs2);
    case (f3[1:0])
      2'b00:   store_wdata = {4{rs2[7:0]}};
      2'b01:   store_wdata = {2{rs2[15:0]}};
      default: store_wdata = rs2;
    endcase
  endfunction

  // Non-memory instructions have no load data; a MEM select falls back to the ALU value
  function automatic logic [WIDTH-1:0] wb_mux(input logic [1:0] sel, input logic [WIDTH-1:0] alu,
                                              input logic [WIDTH-1:0] pc4,
                                              input logic [WIDTH-1:0] imm);
    case (sel)
      2'b10:   wb_mux = pc4;
      2'b11:   wb_mux = imm;
      default: wb_mux = alu;
    endcase
  endfunction

  assign accept = en && i_valid && (state == S_IDLE);
  assign is_mem = i_mem_read_en || i_mem_write_en;

`ifdef P_MEM_WB_MISALIGN_CHECK_EN
  assign misal_now = ((i_funct3[1:0] == 2'b01) && i_alu_result[0]) ||
                     ((i_funct3[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00));
`else
  assign misal_now = 1'b0;
`endif

  assign mem_go  = accept && is_mem && !misal_now;
  assign alu_go  = accept && !is_mem;
  assign tmo_hit = (MAX_WAIT > 0) && (state == S_WAIT) && !i_dmem_ack &&
                   (int'(wait_cnt) == MAX_WAIT - 1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (mem_go) state_n = S_WAIT;
      S_WAIT: if (i_dmem_ack || tmo_hit) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Stall output: hold upstream from issue until ack or timeout
  always_comb begin
    o_stall = 1'b0;
    case (state)
      S_IDLE: o_stall = mem_go;
      S_WAIT: o_stall = !i_dmem_ack && !tmo_hit;
      default: o_stall = 1'b0;
    endcase
  end

  // Memory request, wait counter and write-back registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_dmem_req       <= 1'b0;
      o_dmem_we        <= 1'b0;
      o_dmem_addr      <= '0;
      o_dmem_wdata     <= '0;
      o_dmem_be        <= '0;
      f3_p0            <= '0;
      rd_p0            <= '0;
      off_p0           <= '0;
      rw_p0            <= 1'b0;
      ld_p0            <= 1'b0;
      wait_cnt         <= '0;
      o_bus_err        <= 1'b0;
      ext_reg_write_en <= 1'b0;
      ext_rd_addr      <= '0;
      ext_rd_data      <= '0;
    end else begin
      o_bus_err        <= tmo_hit;
      ext_reg_write_en <= 1'b0;
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (mem_go) begin
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= i_mem_write_en;
            o_dmem_addr  <= {i_alu_result[WIDTH-1:2], 2'b00};
            o_dmem_wdata <= store_wdata(i_funct3, i_rs2_data);
            o_dmem_be    <= store_be(i_funct3, i_alu_result[1:0], i_mem_write_en);
            f3_p0        <= i_funct3;
            rd_p0        <= i_rd_addr;
            off_p0       <= i_alu_result[1:0];
            rw_p0        <= i_reg_write_en;
            ld_p0        <= i_mem_read_en;
          end else if (alu_go) begin
            ext_reg_write_en <= i_reg_write_en && (i_rd_addr != 5'd0);
            ext_rd_addr      <= i_rd_addr;
            ext_rd_data      <= wb_mux(i_wb_sel, i_alu_result, i_pc_plus_4, i_imm);
          end
        end
        S_WAIT: begin
          if (i_dmem_ack) begin
            o_dmem_req <= 1'b0;
            wait_cnt   <= '0;
            if (ld_p0) begin
              ext_reg_write_en <= rw_p0 && (rd_p0 != 5'd0);
              ext_rd_addr      <= rd_p0;
              ext_rd_data      <= load_align(i_dmem_rdata, off_p0, f3_p0);
            end
          end else if (tmo_hit) begin
            o_dmem_req <= 1'b0;
            wait_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: o_dmem_req <= 1'b0;
      endcase
    end
  end

`ifdef P_MEM_WB_MISALIGN_CHECK_EN
  // One-cycle trap pulse for a rejected misaligned access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) o_misaligned <= 1'b0;
    else      o_misaligned <= accept && is_mem && misal_now;
  end
`endif

endmodule

// File: tb/tb_p_mem_wb_stage.sv
// tb_p_mem_wb_stage: directed vector bench for p_mem_wb_stage.
module tb_p_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        i_valid;
  logic        i_reg_write_en, i_mem_write_en, i_mem_read_en;
  logic [1:0]  i_wb_sel;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_alu_result, i_rs2_data, i_pc_plus_4, i_imm;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_stall, o_bus_err;
  logic        ext_reg_write_en;
  logic [4:0]  ext_rd_addr;
  logic [31:0] ext_rd_data;
`ifdef P_MEM_WB_MISALIGN_CHECK_EN
  logic        o_misaligned;
`endif

  int total = 0;
  int bad   = 0;

  p_mem_wb_stage #(.WIDTH(32), .MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst), .en(en), .i_valid(i_valid),
    .i_reg_write_en(i_reg_write_en), .i_mem_write_en(i_mem_write_en),
    .i_mem_read_en(i_mem_read_en), .i_wb_sel(i_wb_sel), .i_funct3(i_funct3),
    .i_rd_addr(i_rd_addr), .i_alu_result(i_alu_result), .i_rs2_data(i_rs2_data),
    .i_pc_plus_4(i_pc_plus_4), .i_imm(i_imm),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
    .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
    .o_stall(o_stall), .o_bus_err(o_bus_err),
    .ext_reg_write_en(ext_reg_write_en), .ext_rd_addr(ext_rd_addr),
    .ext_rd_data(ext_rd_data)
`ifdef P_MEM_WB_MISALIGN_CHECK_EN
    , .o_misaligned(o_misaligned)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        rw;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic        exp_we;
    logic        chk;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; en = 1'b1;
    i_reg_write_en = 1'b0; i_mem_write_en = 1'b0; i_mem_read_en = 1'b0;
    i_wb_sel = 2'b00; i_funct3 = 3'b000; i_rd_addr = 5'd0;
    i_alu_result = '0; i_rs2_data = '0; i_pc_plus_4 = '0; i_imm = '0;
    i_dmem_ack = 1'b0; i_dmem_rdata = '0;
  endtask

  // Issue one memory instruction, answer after n_wait ack-less WAIT cycles.
  // Returns number of stalled cycles and the bus signals seen while waiting.
  task automatic mem_access(input logic ld, input logic [2:0] f3, input logic [4:0] rd,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input int n_wait, input logic [31:0] rdata,
                            output int sc, output logic c_req, output logic c_we,
                            output logic [31:0] c_addr, output logic [31:0] c_wdata,
                            output logic [3:0] c_be);
    @(negedge clk);
    i_valid = 1'b1; en = 1'b1;
    i_mem_read_en = ld; i_mem_write_en = !ld; i_reg_write_en = ld;
    i_wb_sel = ld ? 2'b01 : 2'b00; i_funct3 = f3; i_rd_addr = rd;
    i_alu_result = addr; i_rs2_data = rs2;
    #1 sc = int'(o_stall);
    for (int i = 0; i < n_wait; i++) begin
      @(negedge clk);
      #1 sc += int'(o_stall);
    end
    @(negedge clk);
    c_req = o_dmem_req; c_we = o_dmem_we; c_addr = o_dmem_addr;
    c_wdata = o_dmem_wdata; c_be = o_dmem_be;
    i_dmem_ack = 1'b1; i_dmem_rdata = rdata;
    #1 sc += int'(o_stall);
    @(negedge clk);
    idle_inputs();
  endtask

  int          sc, reqcnt, errcnt, wecnt;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata;
  logic [3:0]  c_be;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           en  rw  sel    rd     alu            pc4            imm            we  chk rd     data
    vecs[0] = '{1'b1, 1'b1, 2'b00, 5'd5,  32'h0000_0042, 32'h0000_0111, 32'h0000_0222, 1'b1, 1'b1, 5'd5,  32'h0000_0042};
    vecs[1] = '{1'b1, 1'b1, 2'b10, 5'd1,  32'h0000_0999, 32'h0000_0104, 32'h0000_0333, 1'b1, 1'b1, 5'd1,  32'h0000_0104};
    vecs[2] = '{1'b1, 1'b1, 2'b11, 5'd31, 32'h0000_0001, 32'h0000_0002, 32'hDEAD_B000, 1'b1, 1'b1, 5'd31, 32'hDEAD_B000};
    vecs[3] = '{1'b0, 1'b1, 2'b00, 5'd9,  32'h0000_0777, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b1, 5'd31, 32'hDEAD_B000};
    vecs[4] = '{1'b1, 1'b1, 2'b10, 5'd0,  32'h0000_0005, 32'h0000_0104, 32'h0000_0006, 1'b0, 1'b0, 5'd0,  32'h0000_0000};
    vecs[5] = '{1'b1, 1'b0, 2'b00, 5'd7,  32'h0000_0888, 32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0, 5'd0,  32'h0000_0000};
    vecs[6] = '{1'b1, 1'b1, 2'b00, 5'd2,  32'hFFFF_FFFF, 32'h0000_0009, 32'h0000_000A, 1'b1, 1'b1, 5'd2,  32'hFFFF_FFFF};

    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rst req", o_dmem_req, 0);
    chk("rst we", o_dmem_we, 0);
    chk("rst be", o_dmem_be, 0);
    chk("rst addr", o_dmem_addr, 0);
    chk("rst wdata", o_dmem_wdata, 0);
    chk("rst ext_we", ext_reg_write_en, 0);
    chk("rst ext_rd", ext_rd_addr, 0);
    chk("rst ext_data", ext_rd_data, 0);
    chk("rst bus_err", o_bus_err, 0);
    chk("rst stall", o_stall, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Non-memory instructions: latency 1, then a bubble that holds rd/data
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      en = vecs[k].en; i_valid = 1'b1;
      i_reg_write_en = vecs[k].rw; i_wb_sel = vecs[k].sel; i_rd_addr = vecs[k].rd;
      i_alu_result = vecs[k].alu; i_pc_plus_4 = vecs[k].pc4; i_imm = vecs[k].imm;
      #1 chk($sformatf("vec%0d stall", k), o_stall, 0);
      @(negedge clk);
      i_valid = 1'b0; en = 1'b1;
      chk($sformatf("vec%0d we", k), ext_reg_write_en, vecs[k].exp_we);
      if (vecs[k].chk) begin
        chk($sformatf("vec%0d rd", k), ext_rd_addr, vecs[k].exp_rd);
        chk($sformatf("vec%0d data", k), ext_rd_data, vecs[k].exp_data);
      end
      @(negedge clk);
      chk($sformatf("vec%0d bubble we", k), ext_reg_write_en, 0);
      if (vecs[k].chk) begin
        chk($sformatf("vec%0d hold rd", k), ext_rd_addr, vecs[k].exp_rd);
        chk($sformatf("vec%0d hold data", k), ext_rd_data, vecs[k].exp_data);
      end
    end

    // LB at 0x1003, ack after 3 WAIT cycles
    mem_access(1'b1, 3'b000, 5'd10, 32'h0000_1003, 32'h0, 3, 32'h80AA_BBCC,
               sc, c_req, c_we, c_addr, c_wdata, c_be);
    chk("lb stall cycles", sc, 4);
    chk("lb req", c_req, 1);
    chk("lb we", c_we, 0);
    chk("lb addr", c_addr, 32'h0000_1000);
    chk("lb be", c_be, 4'b1111);
    chk("lb ext_we", ext_reg_write_en, 1);
    chk("lb ext_rd", ext_rd_addr, 10);
    chk("lb ext_data", ext_rd_data, 32'hFFFF_FF80);
    chk("lb req dropped", o_dmem_req, 0);
    @(negedge clk);
    chk("lb pulse", ext_reg_write_en, 0);

    // LBU, same access
    mem_access(1'b1, 3'b100, 5'd11, 32'h0000_1003, 32'h0, 3, 32'h80AA_BBCC,
               sc, c_req, c_we, c_addr, c_wdata, c_be);
    chk("lbu stall cycles", sc, 4);
    chk("lbu ext_we", ext_reg_write_en, 1);
    chk("lbu ext_data", ext_rd_data, 32'h0000_0080);

    // SH at 0x2002: upper half lanes, no write-back
    mem_access(1'b0, 3'b001, 5'd12, 32'h0000_2002, 32'h1234_ABCD, 1, 32'h0,
               sc, c_req, c_we, c_addr, c_wdata, c_be);
    chk("sh stall cycles", sc, 2);
    chk("sh we", c_we, 1);
    chk("sh be", c_be, 4'b1100);
    chk("sh wdata", c_wdata, 32'hABCD_ABCD);
    chk("sh addr", c_addr, 32'h0000_2000);
    chk("sh ext_we", ext_reg_write_en, 0);
    chk("sh hold data", ext_rd_data, 32'h0000_0080);

    // SB at 0x3001
    mem_access(1'b0, 3'b000, 5'd0, 32'h0000_3001, 32'hFFFF_FF55, 0, 32'h0,
               sc, c_req, c_we, c_addr, c_wdata, c_be);
    chk("sb be", c_be, 4'b0010);
    chk("sb wdata", c_wdata, 32'h5555_5555);
    chk("sb ext_we", ext_reg_write_en, 0);

    // LH at 0x4002 (upper half, negative)
    mem_access(1'b1, 3'b001, 5'd13, 32'h0000_4002, 32'h0, 2, 32'h8001_1234,
               sc, c_req, c_we, c_addr, c_wdata, c_be);
    chk("lh ext_data", ext_rd_data, 32'hFFFF_8001);

    // LW with immediate ack: stall only in the issue cycle
    mem_access(1'b1, 3'b010, 5'd14, 32'h0000_4000, 32'h0, 0, 32'hCAFE_F00D,
               sc, c_req, c_we, c_addr, c_wdata, c_be);
    chk("lw stall cycles", sc, 1);
    chk("lw ext_rd", ext_rd_addr, 14);
    chk("lw ext_data", ext_rd_data, 32'hCAFE_F00D);

    // Ack while idle is ignored
    @(negedge clk);
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    i_dmem_ack = 1'b0;
    chk("idle ack ext_we", ext_reg_write_en, 0);
    chk("idle ack req", o_dmem_req, 0);
    chk("idle ack data", ext_rd_data, 32'hCAFE_F00D);

    // LW with no ack: bus timeout after 16 WAIT cycles
    @(negedge clk);
    i_valid = 1'b1; i_mem_read_en = 1'b1; i_reg_write_en = 1'b1; i_wb_sel = 2'b01;
    i_funct3 = 3'b010; i_rd_addr = 5'd15; i_alu_result = 32'h0000_5000;
    reqcnt = 0; errcnt = 0; wecnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!o_dmem_req) begin
        i_valid = 1'b0; i_mem_read_en = 1'b0; i_reg_write_en = 1'b0;
      end
      #1;
      reqcnt += int'(o_dmem_req);
      errcnt += int'(o_bus_err);
      wecnt  += int'(ext_reg_write_en);
    end
    chk("tmo req cycles", reqcnt, 16);
    chk("tmo bus_err pulses", errcnt, 1);
    chk("tmo writes", wecnt, 0);
    chk("tmo stall released", o_stall, 0);

    // Reset during WAIT drops the request; a late ack writes nothing
    @(negedge clk);
    i_valid = 1'b1; i_mem_read_en = 1'b1; i_reg_write_en = 1'b1; i_wb_sel = 2'b01;
    i_funct3 = 3'b010; i_rd_addr = 5'd16; i_alu_result = 32'h0000_6000;
    @(negedge clk);
    chk("pre-rst req", o_dmem_req, 1);
    #2 rst = 1'b0;
    i_valid = 1'b0; i_mem_read_en = 1'b0; i_reg_write_en = 1'b0;
    #1;
    chk("rst mid-wait req", o_dmem_req, 0);
    chk("rst mid-wait stall", o_stall, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    i_dmem_ack = 1'b1; i_dmem_rdata = 32'h2222_2222;
    @(negedge clk);
    i_dmem_ack = 1'b0;
    wecnt = 0;
    for (int c = 0; c < 3; c++) begin
      #1 wecnt += int'(ext_reg_write_en) + int'(o_dmem_req);
      @(negedge clk);
    end
    chk("late ack activity", wecnt, 0);
    chk("late ack data", ext_rd_data, 32'h0);

`ifdef P_MEM_WB_MISALIGN_CHECK_EN
    // Misaligned LW: trapped without a request or stall
    @(negedge clk);
    i_valid = 1'b1; i_mem_read_en = 1'b1; i_reg_write_en = 1'b1; i_wb_sel = 2'b01;
    i_funct3 = 3'b010; i_rd_addr = 5'd17; i_alu_result = 32'h0000_1001;
    #1 chk("misal stall", o_stall, 0);
    @(negedge clk);
    idle_inputs();
    chk("misal pulse", o_misaligned, 1);
    reqcnt = int'(o_dmem_req); wecnt = int'(ext_reg_write_en);
    @(negedge clk);
    chk("misal pulse end", o_misaligned, 0);
    reqcnt += int'(o_dmem_req); wecnt += int'(ext_reg_write_en);
    chk("misal req", reqcnt, 0);
    chk("misal write", wecnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
